configuration_registers_rx_fifo: RTL and testbench
==================================================

// Module: configuration_registers_rx_fifo
// PURPOSE
//  Deserialises {address, data[, checksum]} frames from the byte-wide rx stream into full-width register writes.
//  Parametrised successor of the single-frame config receiver:
//   - generic address/data widths and packet order
//   - OUT_DEPTH-entry output FIFO, so reception continues while the register bank is busy
//   - inter-packet timeout that aborts partial frames
//  Sits between the host rx FIFO and the configuration register bank.
// PARAMETERS
//  RX_DATA_WIDTH   8    rx packet width; REG_ADDR_WIDTH and REG_DATA_WIDTH are integer multiples of it
//  REG_ADDR_WIDTH  16   register address width; A = REG_ADDR_WIDTH/RX_DATA_WIDTH packets
//  REG_DATA_WIDTH  16   register data width; D = REG_DATA_WIDTH/RX_DATA_WIDTH packets
//  MSB_FIRST       0    0: first packet of a field -> bits [RX_DATA_WIDTH-1:0]; 1: first packet -> field MSBs
//  OUT_DEPTH       4    output FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES  1024 max clk cycles between packets inside a frame; 0 disables timeout
// PORTS
//  clk            in   1               fpga clock
//  rst            in   1               reset rst, synchronous, active-high
//  rx_data        in   RX_DATA_WIDTH   incoming packet
//  rx_rdy         in   1               packet valid
//  rx_ack         out  1               packet consumed this cycle (combinational)
//  register_addr  out  REG_ADDR_WIDTH  FIFO head address
//  register_data  out  REG_DATA_WIDTH  FIFO head data
//  register_rdy   out  1               FIFO not empty
//  register_ack   in   1               pop FIFO head when register_rdy=1
//  timeout_err    out  1               1-cycle pulse: partial frame aborted
//  chk_err        out  1               1-cycle pulse: bad checksum (0 when CHECKSUM_EN undefined)
// BEHAVIOUR
//  Reset: register_rdy=0, timeout_err=0, chk_err=0, FIFO empty, state=ST_ADDR, count=0, timer=0.
//   register_addr/register_data are don't-care while register_rdy=0.
//  Handshake: packet transfers on a cycle with rx_rdy=1 and rx_ack=1. rx_ack = rx_rdy & ~stall.
//   stall=1 only when the frame-completing packet is presented and the FIFO is full.
//  FSM:
//   ST_ADDR: store A packets -> ST_DATA.
//   ST_DATA: store D packets -> push frame, return to ST_ADDR (or -> ST_CHK with CHECKSUM_EN).
//   ST_CHK: 1 packet; compare, push on match -> ST_ADDR.
//   count is cleared on every state change.
//  Latency: register_rdy rises on the edge accepting the frame-completing packet.
//   Visible the cycle after that edge when the FIFO was empty.
//  FIFO: push and pop in the same cycle are both honoured, so occupancy is unchanged.
//   A pop of the last entry with no push drops register_rdy on the next edge. Pointers wrap modulo OUT_DEPTH.
//  FIFO full: the frame-completing packet is held off (rx_ack=0); no data is lost or overwritten.
//   Earlier packets of the next frame are still accepted.
//  Timeout: timer counts cycles in a frame (state!=ST_ADDR or count!=0) without an accepted packet.
//   Timer clears on every accepted packet and is frozen while stall=1.
//   timer==TIMEOUT_CYCLES-1 -> state=ST_ADDR, count=0, timeout_err pulses; FIFO untouched.
//  Simultaneous timeout expiry and packet acceptance: the packet wins, timer clears, no error.
//  rst mid-frame or with a non-empty FIFO: partial frame and all FIFO entries discarded.
// CONFIGURATION
//  CHECKSUM_EN defined:
//   - frame gains one trailing packet = XOR of all A+D packets
//   - mismatch: frame discarded, chk_err pulses on the edge after the checksum is accepted, state -> ST_ADDR
//   - the checksum packet is the frame-completing packet for stall purposes
//  CHECKSUM_EN undefined:
//   - ST_CHK absent; frame is A+D packets
//   - chk_err tied to 0
// TESTING
//  1 Defaults, MSB_FIRST=0, send 34 12 CD AB, register_ack=1:
//    -> one cycle with register_rdy=1, addr=0x1234, data=0xABCD.
//  2 MSB_FIRST=1, send 12 34 AB CD -> addr=0x1234, data=0xABCD.
//  3 register_ack=0, send 5 frames, rx_rdy held 1:
//    -> 4 frames queued; 5th frame's last packet stalls (rx_ack=0).
//    -> after one pop, 5th frame enters; order preserved.
//  4 TIMEOUT_CYCLES=8, send 2 packets then idle 8 cycles:
//    -> timeout_err pulses once; next full frame decodes correctly.
//  5 CHECKSUM_EN, frame 34 12 CD AB + checksum 0x00 -> chk_err pulse, FIFO stays empty.
//    Checksum 0x00 is wrong; correct value is 0x34^0x12^0xCD^0xAB=0x40.
//    Frame with checksum 0x40 -> queued, chk_err=0.
//  6 Assert rst after 3 packets with 2 frames queued:
//    -> register_rdy=0 next cycle; fresh frame decodes correctly.

Source files
------------

// File: rtl/configuration_registers_rx_fifo.sv
// Deserialises {address, data[, checksum]} rx frames into queued register writes.
// Optional trailing XOR checksum packet enabled by defining CHECKSUM_EN.
module configuration_registers_rx_fifo #(
  parameter int RX_DATA_WIDTH  = 8,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_DATA_WIDTH = 16,
  parameter int MSB_FIRST      = 0,
  parameter int OUT_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RX_DATA_WIDTH-1:0]  rx_data,
  input  logic                      rx_rdy,
  output logic                      rx_ack,
  output logic [REG_ADDR_WIDTH-1:0] register_addr,
  output logic [REG_DATA_WIDTH-1:0] register_data,
  output logic                      register_rdy,
  input  logic                      register_ack,
  output logic                      timeout_err,
  output logic                      chk_err
);

  localparam int A_PKTS   = REG_ADDR_WIDTH / RX_DATA_WIDTH;
  localparam int D_PKTS   = REG_DATA_WIDTH / RX_DATA_WIDTH;
  localparam int MAX_PKTS = (A_PKTS > D_PKTS) ? A_PKTS : D_PKTS;
  localparam int CNT_W    = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam int PTR_W    = $clog2(OUT_DEPTH);
  localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_ADDR = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
`ifdef CHECKSUM_EN
  localparam logic [1:0] ST_CHK  = 2'd2;
`endif

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] data_q, data_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic                      timeout_err_q, timeout_err_d;
`ifdef CHECKSUM_EN
  logic [RX_DATA_WIDTH-1:0]  chk_q, chk_d;
  logic                      chk_err_q, chk_err_d;
`endif

  logic [REG_ADDR_WIDTH-1:0] addr_mem_q [OUT_DEPTH];
  logic [REG_DATA_WIDTH-1:0] data_mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]            occ_q, occ_d;

  logic             last_pkt;
  logic             fifo_full;
  logic             stall;
  logic             accept;
  logic             push;
  logic             pop;
  logic             in_frame;
  logic [CNT_W-1:0] addr_slot;
  logic [CNT_W-1:0] data_slot;

  // Only the frame-completing packet can be held off; earlier packets never touch the FIFO
  always_comb begin
`ifdef CHECKSUM_EN
    last_pkt = (state_q == ST_CHK);
`else
    last_pkt = (state_q == ST_DATA) && (count_q == CNT_W'(D_PKTS - 1));
`endif
    fifo_full    = (occ_q == (PTR_W + 1)'(OUT_DEPTH));
    stall        = rx_rdy & last_pkt & fifo_full;
    rx_ack       = rx_rdy & ~stall;
    accept       = rx_ack;
    register_rdy = (occ_q != '0);
    pop          = register_ack & register_rdy;
    in_frame     = (state_q != ST_ADDR) || (count_q != '0);
    addr_slot    = (MSB_FIRST != 0) ? (CNT_W'(A_PKTS - 1) - count_q) : count_q;
    data_slot    = (MSB_FIRST != 0) ? (CNT_W'(D_PKTS - 1) - count_q) : count_q;
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    addr_d        = addr_q;
    data_d        = data_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
    push          = 1'b0;
`ifdef CHECKSUM_EN
    chk_d         = chk_q;
    chk_err_d     = 1'b0;
`endif
    if (accept) begin
      timer_d = '0;
`ifdef CHECKSUM_EN
      chk_d = chk_q ^ rx_data;
`endif
      case (state_q)
        ST_ADDR: begin
          for (int i = 0; i < A_PKTS; i++) begin
            if (addr_slot == CNT_W'(i)) addr_d[i*RX_DATA_WIDTH +: RX_DATA_WIDTH] = rx_data;
          end
          if (count_q == CNT_W'(A_PKTS - 1)) begin
            state_d = ST_DATA;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          for (int i = 0; i < D_PKTS; i++) begin
            if (data_slot == CNT_W'(i)) data_d[i*RX_DATA_WIDTH +: RX_DATA_WIDTH] = rx_data;
          end
          if (count_q == CNT_W'(D_PKTS - 1)) begin
            count_d = '0;
`ifdef CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_ADDR;
            push    = 1'b1;
`endif
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
`ifdef CHECKSUM_EN
        ST_CHK: begin
          if (rx_data == chk_q) push = 1'b1;
          else                  chk_err_d = 1'b1;
          chk_d   = '0;
          state_d = ST_ADDR;
          count_d = '0;
        end
`endif
        default: begin
          state_d = ST_ADDR;
          count_d = '0;
        end
      endcase
    end else if (in_frame && !stall) begin
      if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
        state_d       = ST_ADDR;
        count_d       = '0;
        timer_d       = '0;
        timeout_err_d = 1'b1;
`ifdef CHECKSUM_EN
        chk_d         = '0;
`endif
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end else if (!in_frame) begin
      timer_d = '0;
    end
  end

  // A push never coincides with a full FIFO, so occupancy cannot overflow
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + (PTR_W + 1)'(1);
    else if (!push && pop) occ_d = occ_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ADDR;
      count_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
`ifdef CHECKSUM_EN
      chk_q         <= '0;
      chk_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
`ifdef CHECKSUM_EN
      chk_q         <= chk_d;
      chk_err_q     <= chk_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= addr_d;
      data_mem_q[wr_ptr_q] <= data_d;
    end
  end

  assign register_addr = addr_mem_q[rd_ptr_q];
  assign register_data = data_mem_q[rd_ptr_q];
  assign timeout_err   = timeout_err_q;
`ifdef CHECKSUM_EN
  assign chk_err       = chk_err_q;
`else
  assign chk_err       = 1'b0;
`endif

endmodule

// File: tb/tb_configuration_registers_rx_fifo.sv
// Directed bench for configuration_registers_rx_fifo: byte order, FIFO full stall,
// timeout abort, checksum (when CHECKSUM_EN is defined) and mid-frame reset.
module tb_configuration_registers_rx_fifo;

   logic        clk;
   logic        rst;
   logic [7:0]  rxDataA, rxDataB;
   logic        rxRdyA, rxRdyB;
   logic        rxAckA, rxAckB;
   logic [15:0] regAddrA, regAddrB;
   logic [15:0] regDataA, regDataB;
   logic        regRdyA, regRdyB;
   logic        regAckA, regAckB;
   logic        timeoutErrA, timeoutErrB;
   logic        chkErrA, chkErrB;

   int compareCount;
   int mismatchCount;
   logic [7:0] frameBytes[$];

   // LSB-first instance with a short timeout
   configuration_registers_rx_fifo #(
      .RX_DATA_WIDTH(8), .REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(16),
      .MSB_FIRST(0), .OUT_DEPTH(4), .TIMEOUT_CYCLES(8)
   ) dutA (
      .clk(clk), .rst(rst), .rx_data(rxDataA), .rx_rdy(rxRdyA), .rx_ack(rxAckA),
      .register_addr(regAddrA), .register_data(regDataA), .register_rdy(regRdyA),
      .register_ack(regAckA), .timeout_err(timeoutErrA), .chk_err(chkErrA)
   );

   // MSB-first instance with default timeout
   configuration_registers_rx_fifo #(
      .RX_DATA_WIDTH(8), .REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(16),
      .MSB_FIRST(1), .OUT_DEPTH(4), .TIMEOUT_CYCLES(1024)
   ) dutB (
      .clk(clk), .rst(rst), .rx_data(rxDataB), .rx_rdy(rxRdyB), .rx_ack(rxAckB),
      .register_addr(regAddrB), .register_data(regDataB), .register_rdy(regRdyB),
      .register_ack(regAckB), .timeout_err(timeoutErrB), .chk_err(chkErrB)
   );

   // 10 ns clock; stimulus changes and sampling happen around the falling edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one byte from a falling edge and returns at the falling edge after it was accepted
   task automatic applyStimulus(input logic sel, input logic [7:0] b);
      int waitCycles;
      logic acked;
      waitCycles = 0;
      if (sel) begin rxDataB = b; rxRdyB = 1'b1; end
      else     begin rxDataA = b; rxRdyA = 1'b1; end
      #1;
      acked = sel ? rxAckB : rxAckA;
      while (!acked && waitCycles < 40) begin
         @(negedge clk);
         #1;
         acked = sel ? rxAckB : rxAckA;
         waitCycles++;
      end
      if (!acked) checkOutput("rx_ack_wait", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   // Byte sequence of one frame, with the XOR checksum appended when the design expects it
   task automatic buildFrame(input logic msbFirst, input logic [15:0] addr, input logic [15:0] data);
      logic [7:0] chk;
      frameBytes.delete();
      if (msbFirst) begin
         frameBytes.push_back(addr[15:8]); frameBytes.push_back(addr[7:0]);
         frameBytes.push_back(data[15:8]); frameBytes.push_back(data[7:0]);
      end else begin
         frameBytes.push_back(addr[7:0]);  frameBytes.push_back(addr[15:8]);
         frameBytes.push_back(data[7:0]);  frameBytes.push_back(data[15:8]);
      end
      chk = addr[15:8] ^ addr[7:0] ^ data[15:8] ^ data[7:0];
`ifdef CHECKSUM_EN
      frameBytes.push_back(chk);
`else
      chk = 8'h00;
`endif
   endtask

   task automatic sendFrame(input logic sel, input logic [15:0] addr, input logic [15:0] data);
      logic [7:0] bytesToSend[$];
      buildFrame(sel, addr, data);
      bytesToSend = frameBytes;
      foreach (bytesToSend[i]) applyStimulus(sel, bytesToSend[i]);
      if (sel) rxRdyB = 1'b0;
      else     rxRdyA = 1'b0;
   endtask

   // Checks the FIFO head of dutA and pops it across the next rising edge
   task automatic popCheck(input logic [15:0] addr, input logic [15:0] data);
      checkOutput("pop_rdy", {31'd0, regRdyA}, 32'd1);
      checkOutput("pop_addr", {16'd0, regAddrA}, {16'd0, addr});
      checkOutput("pop_data", {16'd0, regDataA}, {16'd0, data});
      regAckA = 1'b1;
      @(negedge clk);
      regAckA = 1'b0;
   endtask

   initial begin
      int pulses;
      int firstPulse;
      logic [7:0] allBytes[$];
      logic [7:0] lastByte;

      compareCount = 0;
      mismatchCount = 0;
      rst = 1'b1;
      rxDataA = 8'h00; rxRdyA = 1'b0; regAckA = 1'b0;
      rxDataB = 8'h00; rxRdyB = 1'b0; regAckB = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_rdy", {31'd0, regRdyA}, 32'd0);
      checkOutput("rst_timeout", {31'd0, timeoutErrA}, 32'd0);
      checkOutput("rst_chk", {31'd0, chkErrA}, 32'd0);
      checkOutput("rst_ack", {31'd0, rxAckA}, 32'd0);
      checkOutput("rst_rdy_b", {31'd0, regRdyB}, 32'd0);

      $display("[TB] LSB-first frame");
      regAckA = 1'b1;
      sendFrame(1'b0, 16'h1234, 16'hABCD);
      checkOutput("t1_rdy", {31'd0, regRdyA}, 32'd1);
      checkOutput("t1_addr", {16'd0, regAddrA}, 32'h1234);
      checkOutput("t1_data", {16'd0, regDataA}, 32'hABCD);
      checkOutput("t1_chk", {31'd0, chkErrA}, 32'd0);
      @(negedge clk);
      checkOutput("t1_rdy_drop", {31'd0, regRdyA}, 32'd0);

      $display("[TB] MSB-first frame");
      regAckB = 1'b1;
      sendFrame(1'b1, 16'h1234, 16'hABCD);
      checkOutput("t2_rdy", {31'd0, regRdyB}, 32'd1);
      checkOutput("t2_addr", {16'd0, regAddrB}, 32'h1234);
      checkOutput("t2_data", {16'd0, regDataB}, 32'hABCD);
      @(negedge clk);
      checkOutput("t2_rdy_drop", {31'd0, regRdyB}, 32'd0);

      $display("[TB] timeout after partial frame");
      applyStimulus(1'b0, 8'h34);
      applyStimulus(1'b0, 8'h12);
      rxRdyA = 1'b0;
      pulses = 0;
      firstPulse = -1;
      for (int k = 0; k <= 12; k++) begin
         if (timeoutErrA) begin
            pulses++;
            if (firstPulse < 0) firstPulse = k;
         end
         if (k < 12) @(negedge clk);
      end
      checkOutput("t4_pulses", pulses, 32'd1);
      checkOutput("t4_pulse_cycle", firstPulse, 32'd8);
      checkOutput("t4_fifo_empty", {31'd0, regRdyA}, 32'd0);
      sendFrame(1'b0, 16'h2468, 16'h1357);
      checkOutput("t4_addr", {16'd0, regAddrA}, 32'h2468);
      checkOutput("t4_data", {16'd0, regDataA}, 32'h1357);
      @(negedge clk);

      $display("[TB] FIFO full stall");
      regAckA = 1'b0;
      allBytes.delete();
      for (int f = 0; f < 5; f++) begin
         buildFrame(1'b0, 16'h0100 + 16'(f), 16'hA000 + 16'(f * 17));
         foreach (frameBytes[i]) allBytes.push_back(frameBytes[i]);
      end
      lastByte = allBytes.pop_back();
      foreach (allBytes[i]) applyStimulus(1'b0, allBytes[i]);
      rxDataA = lastByte;
      rxRdyA = 1'b1;
      #1;
      checkOutput("t3_stall_ack", {31'd0, rxAckA}, 32'd0);
      checkOutput("t3_full_rdy", {31'd0, regRdyA}, 32'd1);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (timeoutErrA) pulses++;
      end
      #1;
      checkOutput("t3_stall_hold", {31'd0, rxAckA}, 32'd0);
      checkOutput("t3_no_timeout", pulses, 32'd0);
      popCheck(16'h0100, 16'hA000);
      #1;
      checkOutput("t3_release_ack", {31'd0, rxAckA}, 32'd1);
      @(negedge clk);
      rxRdyA = 1'b0;
      for (int f = 1; f < 5; f++) popCheck(16'h0100 + 16'(f), 16'hA000 + 16'(f * 17));
      checkOutput("t3_drained", {31'd0, regRdyA}, 32'd0);

`ifdef CHECKSUM_EN
      $display("[TB] checksum");
      regAckA = 1'b1;
      applyStimulus(1'b0, 8'h34);
      applyStimulus(1'b0, 8'h12);
      applyStimulus(1'b0, 8'hCD);
      applyStimulus(1'b0, 8'hAB);
      applyStimulus(1'b0, 8'h00);
      rxRdyA = 1'b0;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         if (chkErrA) pulses++;
         checkOutput("t5_bad_empty", {31'd0, regRdyA}, 32'd0);
         @(negedge clk);
      end
      checkOutput("t5_chk_pulses", pulses, 32'd1);
      sendFrame(1'b0, 16'h1234, 16'hABCD);
      checkOutput("t5_good_rdy", {31'd0, regRdyA}, 32'd1);
      checkOutput("t5_good_addr", {16'd0, regAddrA}, 32'h1234);
      checkOutput("t5_good_data", {16'd0, regDataA}, 32'hABCD);
      checkOutput("t5_good_chk", {31'd0, chkErrA}, 32'd0);
      @(negedge clk);
`endif

      $display("[TB] reset mid-frame with queued entries");
      regAckA = 1'b0;
      sendFrame(1'b0, 16'h1111, 16'h2222);
      sendFrame(1'b0, 16'h3333, 16'h4444);
      applyStimulus(1'b0, 8'h55);
      applyStimulus(1'b0, 8'h66);
      applyStimulus(1'b0, 8'h77);
      rxRdyA = 1'b0;
      checkOutput("t6_queued", {31'd0, regRdyA}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t6_rst_rdy", {31'd0, regRdyA}, 32'd0);
      regAckA = 1'b1;
      sendFrame(1'b0, 16'h0F0F, 16'hF00D);
      checkOutput("t6_rdy", {31'd0, regRdyA}, 32'd1);
      checkOutput("t6_addr", {16'd0, regAddrA}, 32'h0F0F);
      checkOutput("t6_data", {16'd0, regDataA}, 32'hF00D);
      checkOutput("t6_chk", {31'd0, chkErrA}, 32'd0);
      @(negedge clk);
      checkOutput("t6_rdy_drop", {31'd0, regRdyA}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

   // Guards against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
